// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of fetch-port, data-port and memory-side signals
//                that connect the two requesters, mem_arbiter and memory.
//                Signal names keep the arbiter's point of view: the _i
//                signals are arbiter inputs and the _o signals are arbiter
//                outputs.
//  Modports    : slave  - arbiter side (takes requests, drives grants,
//                         responses and the memory control lines)
//                master - environment side (requesters plus memory)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
);
    // Fetch port
    logic              f_req_i;
    logic [AWIDTH-1:0] f_addr_i;
    logic              f_gnt_o;
    logic              f_rsp_valid_o;
    logic [DWIDTH-1:0] f_rsp_data_o;
    // Data port
    logic              d_req_i;
    logic              d_we_i;
    logic [AWIDTH-1:0] d_addr_i;
    logic [DWIDTH-1:0] d_wdata_i;
    logic              d_gnt_o;
    logic              d_rsp_valid_o;
    logic [DWIDTH-1:0] d_rsp_data_o;
    // Memory side
    logic [AWIDTH-1:0] mem_addr_o;
    logic [DWIDTH-1:0] mem_data_o;
    logic              mem_read_en_o;
    logic              mem_write_en_o;
    logic [DWIDTH-1:0] mem_data_i;

    modport slave (
        input  f_req_i, f_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_data_i,
        output f_gnt_o, f_rsp_valid_o, f_rsp_data_o,
        output d_gnt_o, d_rsp_valid_o, d_rsp_data_o,
        output mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
    );

    modport master (
        output f_req_i, f_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_data_i,
        input  f_gnt_o, f_rsp_valid_o, f_rsp_data_o,
        input  d_gnt_o, d_rsp_valid_o, d_rsp_data_o,
        input  mem_addr_o, mem_data_o, mem_read_en_o, mem_write_en_o
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory between the fetch port and the data
//                (load/store) port. At most one access is granted per
//                cycle, round-robin on a tie. Each granted access is
//                tracked through a MEM_LAT-deep tag pipeline so that the
//                returning read data / write acknowledge is steered to the
//                port that issued it.
//  Ports       : clk, rst  - clock, synchronous active-high reset
//                bus       - mem_arbiter_if.slave (fetch port, data port,
//                            memory address/data/enables and read data)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int AWIDTH  = 32,
    parameter int DWIDTH  = 32,
    parameter int MEM_LAT = 1      // memory read latency, 1..4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    mem_arbiter_if.slave bus
);

    localparam logic c_OWNER_FETCH = 1'b0;
    localparam logic c_OWNER_DATA  = 1'b1;

    logic               r_last_owner;
    logic [MEM_LAT-1:0] r_pipe_valid;
    logic [MEM_LAT-1:0] r_pipe_owner;
    logic [MEM_LAT-1:0] r_pipe_write;

    logic w_f_gnt;
    logic w_d_gnt;
    logic w_rsp_valid;
    logic w_rsp_owner;
    logic w_rsp_write;
    logic w_f_rsp_valid;
    logic w_d_rsp_valid;

    // ------------------------------------------------------------------
    // Grant: a lone requester always wins; on a tie the port that did not
    // own the previous grant wins. Nothing is granted while in reset.
    // ------------------------------------------------------------------
    always_comb begin
        w_f_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (!rst) begin
            if (bus.f_req_i && bus.d_req_i) begin
                w_d_gnt = (r_last_owner == c_OWNER_FETCH);
                w_f_gnt = (r_last_owner == c_OWNER_DATA);
            end else begin
                w_f_gnt = bus.f_req_i;
                w_d_gnt = bus.d_req_i;
            end
        end
    end

    assign bus.f_gnt_o = w_f_gnt;
    assign bus.d_gnt_o = w_d_gnt;

    // ------------------------------------------------------------------
    // Memory drive: the granted request goes straight to memory in the
    // grant cycle; the bus is fully zeroed when idle.
    // ------------------------------------------------------------------
    always_comb begin
        bus.mem_addr_o     = '0;
        bus.mem_data_o     = '0;
        bus.mem_read_en_o  = 1'b0;
        bus.mem_write_en_o = 1'b0;
        if (w_f_gnt) begin
            bus.mem_addr_o    = bus.f_addr_i;
            bus.mem_read_en_o = 1'b1;
        end else if (w_d_gnt) begin
            bus.mem_addr_o     = bus.d_addr_i;
            bus.mem_data_o     = bus.d_wdata_i;
            bus.mem_read_en_o  = !bus.d_we_i;
            bus.mem_write_en_o = bus.d_we_i;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin history and tag pipeline. Stage 0 captures the grant;
    // the pipeline advances every cycle, so the last stage lines up with
    // the memory's read data exactly MEM_LAT cycles after the grant edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner <= c_OWNER_FETCH;
            r_pipe_valid <= '0;
            r_pipe_owner <= '0;
            r_pipe_write <= '0;
        end else begin
            if (w_f_gnt) begin
                r_last_owner <= c_OWNER_FETCH;
            end else if (w_d_gnt) begin
                r_last_owner <= c_OWNER_DATA;
            end
            r_pipe_valid[0] <= w_f_gnt | w_d_gnt;
            r_pipe_owner[0] <= w_d_gnt;
            r_pipe_write[0] <= w_d_gnt & bus.d_we_i;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_pipe_valid[i] <= r_pipe_valid[i-1];
                r_pipe_owner[i] <= r_pipe_owner[i-1];
                r_pipe_write[i] <= r_pipe_write[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response steering. The pipeline is only cleared on the reset edge,
    // so the last stage is also masked by rst to keep responses quiet
    // during the first reset cycle.
    // ------------------------------------------------------------------
    assign w_rsp_valid   = r_pipe_valid[MEM_LAT-1] && !rst;
    assign w_rsp_owner   = r_pipe_owner[MEM_LAT-1];
    assign w_rsp_write   = r_pipe_write[MEM_LAT-1];
    assign w_f_rsp_valid = w_rsp_valid && (w_rsp_owner == c_OWNER_FETCH);
    assign w_d_rsp_valid = w_rsp_valid && (w_rsp_owner == c_OWNER_DATA);

    assign bus.f_rsp_valid_o = w_f_rsp_valid;
    assign bus.f_rsp_data_o  = w_f_rsp_valid ? bus.mem_data_i : '0;
    assign bus.d_rsp_valid_o = w_d_rsp_valid;
    // Write acknowledges carry no data.
    assign bus.d_rsp_data_o  = (w_d_rsp_valid && !w_rsp_write) ? bus.mem_data_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Two instances run
//                side by side on identical stimulus (MEM_LAT = 1 and 3),
//                each attached to its own behavioural memory. A reference
//                model (grant rules plus a list of issued accesses with
//                their issue cycle) predicts every output every cycle;
//                a vector table and short directed sequences cover the
//                listed corner cases, followed by random traffic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus1 ();
    mem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus3 ();

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    mem_arbiter #(.AWIDTH(32), .DWIDTH(32), .MEM_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of a never-written memory word.
    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    // ---------------- behavioural memories ----------------
    logic [31:0] mem1 [logic [31:0]];
    logic [31:0] mem3 [logic [31:0]];
    logic [31:0] rd1;
    logic [31:0] rd3 [3];

    always @(posedge clk) begin
        if (bus1.mem_write_en_o) mem1[bus1.mem_addr_o] = bus1.mem_data_o;
        rd1 <= bus1.mem_read_en_o ? (mem1.exists(bus1.mem_addr_o) ? mem1[bus1.mem_addr_o]
                                     : init_word(bus1.mem_addr_o)) : 32'hBAAD_F00D;
        if (bus3.mem_write_en_o) mem3[bus3.mem_addr_o] = bus3.mem_data_o;
        rd3[0] <= bus3.mem_read_en_o ? (mem3.exists(bus3.mem_addr_o) ? mem3[bus3.mem_addr_o]
                                        : init_word(bus3.mem_addr_o)) : 32'hBAAD_F00D;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign bus1.mem_data_i = rd1;
    assign bus3.mem_data_i = rd3[2];

    // ---------------- observed outputs ----------------
    typedef struct packed {
        logic        fg;
        logic        dg;
        logic        frv;
        logic [31:0] frd;
        logic        drv;
        logic [31:0] drd;
        logic [31:0] maddr;
        logic [31:0] mdata;
        logic        mrd;
        logic        mwr;
    } out_t;

    out_t live1, live3, obs1, obs3;
    assign live1 = {bus1.f_gnt_o, bus1.d_gnt_o, bus1.f_rsp_valid_o, bus1.f_rsp_data_o,
                    bus1.d_rsp_valid_o, bus1.d_rsp_data_o, bus1.mem_addr_o, bus1.mem_data_o,
                    bus1.mem_read_en_o, bus1.mem_write_en_o};
    assign live3 = {bus3.f_gnt_o, bus3.d_gnt_o, bus3.f_rsp_valid_o, bus3.f_rsp_data_o,
                    bus3.d_rsp_valid_o, bus3.d_rsp_data_o, bus3.mem_addr_o, bus3.mem_data_o,
                    bus3.mem_read_en_o, bus3.mem_write_en_o};

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        bit          is_d;
        logic [31:0] data;
    } rec_t;

    rec_t        recs[$];          // accesses issued, with issue cycle
    logic [31:0] ref_mem [logic [31:0]];
    logic        m_last_d;         // previous grant went to the data port
    int          m_cycle;
    logic        exp_fg_last, exp_dg_last;

    int n_cmp;
    int n_bad;

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, required %h", name, m_cycle, act, exp);
        end
    endtask

    task automatic check_outs(input string t, input out_t a, input out_t e);
        chk({t, ".f_gnt"},        64'(a.fg),    64'(e.fg));
        chk({t, ".d_gnt"},        64'(a.dg),    64'(e.dg));
        chk({t, ".f_rsp_valid"},  64'(a.frv),   64'(e.frv));
        chk({t, ".f_rsp_data"},   64'(a.frd),   64'(e.frd));
        chk({t, ".d_rsp_valid"},  64'(a.drv),   64'(e.drv));
        chk({t, ".d_rsp_data"},   64'(a.drd),   64'(e.drd));
        chk({t, ".mem_addr"},     64'(a.maddr), 64'(e.maddr));
        chk({t, ".mem_data"},     64'(a.mdata), 64'(e.mdata));
        chk({t, ".mem_read_en"},  64'(a.mrd),   64'(e.mrd));
        chk({t, ".mem_write_en"}, 64'(a.mwr),   64'(e.mwr));
    endtask

    // Adds the response due this cycle for a memory of latency lat.
    function automatic out_t add_rsp(input out_t e, input int lat, input logic r);
        out_t x;
        x = e;
        if (!r) begin
            foreach (recs[i]) begin
                if (recs[i].cyc == m_cycle - lat) begin
                    if (recs[i].is_d) begin
                        x.drv = 1'b1;
                        x.drd = recs[i].data;
                    end else begin
                        x.frv = 1'b1;
                        x.frd = recs[i].data;
                    end
                end
            end
        end
        return x;
    endfunction

    // One clock cycle: drive inputs, check both instances, advance model.
    task automatic step(input logic r, input logic fr, input logic [31:0] fa,
                        input logic dr, input logic dwe, input logic [31:0] da,
                        input logic [31:0] dwd);
        out_t e;
        rec_t nr;
        rst = r;
        bus1.f_req_i = fr;  bus1.f_addr_i = fa;
        bus1.d_req_i = dr;  bus1.d_we_i = dwe;  bus1.d_addr_i = da;  bus1.d_wdata_i = dwd;
        bus3.f_req_i = fr;  bus3.f_addr_i = fa;
        bus3.d_req_i = dr;  bus3.d_we_i = dwe;  bus3.d_addr_i = da;  bus3.d_wdata_i = dwd;
        @(negedge clk);
        e    = '0;
        e.fg = !r && fr && (!dr || m_last_d);
        e.dg = !r && dr && (!fr || !m_last_d);
        if (e.fg) begin
            e.maddr = fa;
            e.mrd   = 1'b1;
        end else if (e.dg) begin
            e.maddr = da;
            e.mdata = dwd;
            e.mrd   = !dwe;
            e.mwr   = dwe;
        end
        check_outs("lat1", live1, add_rsp(e, 1, r));
        check_outs("lat3", live3, add_rsp(e, 3, r));
        obs1        = live1;
        obs3        = live3;
        exp_fg_last = e.fg;
        exp_dg_last = e.dg;
        if (r) begin
            recs.delete();
            m_last_d = 1'b0;
        end else if (e.fg) begin
            nr.cyc = m_cycle;  nr.is_d = 1'b0;  nr.data = ref_read(fa);
            recs.push_back(nr);
            m_last_d = 1'b0;
        end else if (e.dg) begin
            nr.cyc = m_cycle;  nr.is_d = 1'b1;  nr.data = dwe ? 32'h0 : ref_read(da);
            recs.push_back(nr);
            if (dwe) ref_mem[da] = dwd;
            m_last_d = 1'b1;
        end
        while (recs.size() > 0 && recs[0].cyc < m_cycle - 8) void'(recs.pop_front());
        m_cycle++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table (MEM_LAT = 1 view) ----------------
    typedef struct {
        logic        r, fr;
        logic [31:0] fa;
        logic        dr, dwe;
        logic [31:0] da, dwd;
        logic        xfg, xdg, xfrv, xdrv;
        logic [31:0] xrd;     // expected f_rsp_data | d_rsp_data
    } vec_t;

    function automatic vec_t mk(input logic r, input logic fr, input logic [31:0] fa,
                                input logic dr, input logic dwe, input logic [31:0] da,
                                input logic [31:0] dwd, input logic xfg, input logic xdg,
                                input logic xfrv, input logic xdrv, input logic [31:0] xrd);
        vec_t v;
        v.r = r;  v.fr = fr;  v.fa = fa;  v.dr = dr;  v.dwe = dwe;  v.da = da;  v.dwd = dwd;
        v.xfg = xfg;  v.xdg = xdg;  v.xfrv = xfrv;  v.xdrv = xdrv;  v.xrd = xrd;
        return v;
    endfunction

    localparam logic [31:0] c_A00 = 32'h0100_0000;
    localparam logic [31:0] c_A04 = 32'h0100_0004;
    localparam logic [31:0] c_A08 = 32'h0100_0008;
    localparam logic [31:0] c_A10 = 32'h0100_0010;
    localparam logic [31:0] c_A20 = 32'h0100_0020;
    localparam logic [31:0] c_BEEF = 32'hDEAD_BEEF;

    vec_t vecs [16];

    logic        pf, pd, pdwe;
    logic [31:0] pfa, pda, pdw;
    int          nf, nd, nidle;

    initial begin
        n_cmp = 0;  n_bad = 0;  m_cycle = 0;  m_last_d = 1'b0;
        rst = 1'b1;
        bus1.f_req_i = 1'b0;  bus1.f_addr_i = '0;  bus1.d_req_i = 1'b0;
        bus1.d_we_i  = 1'b0;  bus1.d_addr_i = '0;  bus1.d_wdata_i = '0;
        bus3.f_req_i = 1'b0;  bus3.f_addr_i = '0;  bus3.d_req_i = 1'b0;
        bus3.d_we_i  = 1'b0;  bus3.d_addr_i = '0;  bus3.d_wdata_i = '0;

        //              r     fr    fa     dr    dwe   da     dwd     fg    dg    frv   drv   rdata
        vecs[0]  = mk(1'b1, 1'b1, c_A00, 1'b1, 1'b0, c_A10, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[1]  = mk(1'b0, 1'b1, c_A00, 1'b1, 1'b0, c_A10, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[2]  = mk(1'b0, 1'b1, c_A00, 1'b0, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, init_word(c_A10));
        vecs[3]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, init_word(c_A00));
        vecs[4]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, c_A20, c_BEEF, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[5]  = mk(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, c_A20, 32'h0,  1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
        vecs[6]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b1, c_BEEF);
        vecs[7]  = mk(1'b0, 1'b1, c_A00, 1'b0, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[8]  = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[10] = mk(1'b0, 1'b1, c_A04, 1'b1, 1'b0, c_A08, 32'h0,  1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        vecs[11] = mk(1'b0, 1'b1, c_A04, 1'b0, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b1, init_word(c_A08));
        vecs[12] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, init_word(c_A04));
        vecs[13] = mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[14] = mk(1'b0, 1'b1, c_A00, 1'b0, 1'b0, 32'h0, 32'h0,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        vecs[15] = mk(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0, init_word(c_A00));

        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].r, vecs[i].fr, vecs[i].fa, vecs[i].dr, vecs[i].dwe, vecs[i].da, vecs[i].dwd);
            chk($sformatf("vec%0d.f_gnt", i),       64'(obs1.fg),  64'(vecs[i].xfg));
            chk($sformatf("vec%0d.d_gnt", i),       64'(obs1.dg),  64'(vecs[i].xdg));
            chk($sformatf("vec%0d.f_rsp_valid", i), 64'(obs1.frv), 64'(vecs[i].xfrv));
            chk($sformatf("vec%0d.d_rsp_valid", i), 64'(obs1.drv), 64'(vecs[i].xdrv));
            chk($sformatf("vec%0d.rsp_data", i),    64'(obs1.frd | obs1.drd), 64'(vecs[i].xrd));
        end

        // Sustained contention: strict alternation starting with data port.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        nf = 0;  nd = 0;  nidle = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 32'h0100_0040, 1'b1, 1'b0, 32'h0100_0044, 32'h0);
            chk($sformatf("contend.d_gnt[%0d]", i), 64'(obs1.dg), 64'((i % 2) == 0));
            nf += int'(obs1.fg);
            nd += int'(obs1.dg);
            if (!obs1.fg && !obs1.dg) nidle++;
        end
        chk("contend.f_grants", 64'(nf), 64'(4));
        chk("contend.d_grants", 64'(nd), 64'(4));
        chk("contend.idle",     64'(nidle), 64'(0));

        // MEM_LAT = 3: back-to-back fetches respond 3 cycles later, adjacent.
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i < 2), c_A00 + 32'(4 * i), 1'b0, 1'b0, 32'h0, 32'h0);
            chk($sformatf("lat3seq.f_rsp_valid[%0d]", i), 64'(obs3.frv), 64'((i == 3) || (i == 4)));
            if (i == 3 || i == 4)
                chk($sformatf("lat3seq.f_rsp_data[%0d]", i), 64'(obs3.frd),
                    64'(init_word(c_A00 + 32'(4 * (i - 3)))));
        end

        // Random traffic honouring the hold-until-granted protocol.
        pf = 1'b0;  pd = 1'b0;  pdwe = 1'b0;  pfa = '0;  pda = '0;  pdw = '0;
        for (int c = 0; c < 600; c++) begin
            if (!pf && $urandom_range(0, 2) != 0) begin
                pf  = 1'b1;
                pfa = c_A00 + 32'(4 * $urandom_range(0, 7));
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd   = 1'b1;
                pdwe = 1'($urandom_range(0, 1));
                pda  = c_A00 + 32'(4 * $urandom_range(0, 7));
                pdw  = $urandom;
            end
            step(1'($urandom_range(0, 49) == 0),
                 pf, pf ? pfa : $urandom, pd, pdwe, pd ? pda : $urandom, pdw);
            if (exp_fg_last) pf = 1'b0;
            if (exp_dg_last) pd = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
